// File: rtl/button_reader.sv
// rtl/button_reader.sv - three-button debouncer with press/release pulses and press counter
//
// Purpose: synchronizes three raw pushbutton inputs, samples them on a slow
// prescaled tick, and accepts a level change only after STABLE_SAMPLES
// consecutive equal samples. Emits one-cycle press/release pulses and keeps
// a modulo-256 running total of accepted presses.
//
// Ports:
//   clk         - system clock, all logic on posedge
//   rst         - synchronous active-high reset
//   btn[2:0]    - raw asynchronous button levels, 1 = pressed
//   btn_level   - debounced level per button
//   btn_press   - one-cycle pulse on accepted 0->1 change
//   btn_release - one-cycle pulse on accepted 1->0 change
//   press_cnt   - running total of accepted presses, all buttons, mod 256
//   tick        - one-cycle sample strobe
module button_reader #(
  parameter int PRESCALE_BITS  = 14,
  parameter int STABLE_SAMPLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] btn,
  output logic [2:0] btn_level,
  output logic [2:0] btn_press,
  output logic [2:0] btn_release,
  output logic [7:0] press_cnt,
  output logic       tick
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    HELD      = 2'd2,
    DISARMING = 2'd3
  } state_t;

  localparam logic [4:0]               STABLE_LIM = 5'(STABLE_SAMPLES);
  localparam logic [PRESCALE_BITS-1:0] PRE_ONE    = {{(PRESCALE_BITS-1){1'b0}}, 1'b1};

  logic [2:0]               sync1;
  logic [2:0]               sync2;
  logic [PRESCALE_BITS-1:0] prescale;
  logic                     msb_q;
  state_t                   state      [3];
  logic [3:0]               stable_cnt [3];

  // Synchronizers, free-running prescaler and tick strobe. The tick is
  // registered from the MSB carry (registered MSB 1, live MSB 0), so it lands
  // one cycle after the prescaler wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      prescale <= '0;
      msb_q    <= 1'b0;
      tick     <= 1'b0;
    end else begin
      sync1    <= btn;
      sync2    <= sync1;
      prescale <= prescale + PRE_ONE;
      msb_q    <= prescale[PRESCALE_BITS-1];
      tick     <= msb_q & ~prescale[PRESCALE_BITS-1];
    end
  end

  // Per-button acceptance FSMs. They only advance on tick cycles, so the
  // press/release pulses they raise appear solely in the cycle after a tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        state[i]      <= IDLE;
        stable_cnt[i] <= 4'd0;
      end
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
    end else begin
      btn_press   <= '0;
      btn_release <= '0;
      if (tick) begin
        for (int i = 0; i < 3; i++) begin
          case (state[i])
            IDLE: begin
              if (sync2[i]) begin
                state[i]      <= ARMING;
                stable_cnt[i] <= 4'd1;
              end
            end
            ARMING: begin
              if (!sync2[i]) begin
                state[i]      <= IDLE;
                stable_cnt[i] <= 4'd0;
              end else if (({1'b0, stable_cnt[i]} + 5'd1) == STABLE_LIM) begin
                state[i]      <= HELD;
                stable_cnt[i] <= 4'd0;
                btn_press[i]  <= 1'b1;
                btn_level[i]  <= 1'b1;
              end else begin
                stable_cnt[i] <= stable_cnt[i] + 4'd1;
              end
            end
            HELD: begin
              if (!sync2[i]) begin
                state[i]      <= DISARMING;
                stable_cnt[i] <= 4'd1;
              end
            end
            DISARMING: begin
              // A single high sample cancels the release; level stays 1.
              if (sync2[i]) begin
                state[i]      <= HELD;
                stable_cnt[i] <= 4'd0;
              end else if (({1'b0, stable_cnt[i]} + 5'd1) == STABLE_LIM) begin
                state[i]       <= IDLE;
                stable_cnt[i]  <= 4'd0;
                btn_release[i] <= 1'b1;
                btn_level[i]   <= 1'b0;
              end else begin
                stable_cnt[i] <= stable_cnt[i] + 4'd1;
              end
            end
            default: begin
              state[i]      <= IDLE;
              stable_cnt[i] <= 4'd0;
            end
          endcase
        end
      end
    end
  end

  // Press total: adds the number of simultaneous press pulses, wrapping at 256.
  always_ff @(posedge clk) begin
    if (rst) begin
      press_cnt <= 8'h00;
    end else begin
      press_cnt <= press_cnt + {7'd0, btn_press[0]} + {7'd0, btn_press[1]}
                             + {7'd0, btn_press[2]};
    end
  end

endmodule

// File: tb/tb_button_reader.sv
// tb/tb_button_reader.sv - directed self-checking bench for button_reader
module tb_button_reader;

  logic       clk;
  logic       rst;
  logic [2:0] btn;
  logic [2:0] btn_level;
  logic [2:0] btn_press;
  logic [2:0] btn_release;
  logic [7:0] press_cnt;
  logic       tick;

  int checks = 0;
  int errors = 0;

  button_reader #(
    .PRESCALE_BITS (4),
    .STABLE_SAMPLES(3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn        (btn),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .press_cnt  (press_cnt),
    .tick       (tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Advance to a negedge where tick is high, then through that tick edge.
  task automatic tick_step();
    int n;
    n = 0;
    while (tick !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check("tick_timeout", {31'd0, tick}, 32'd1);
    step();
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {13'd0, btn_level, btn_press, btn_release, press_cnt, tick}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    btn = 3'b000;
    repeat (3) step();
    check_all_zero("reset_outputs");

    // Tick cadence: first tick after edge 17, then every 16 cycles.
    rst = 1'b0;
    check_all_zero("first_cycle_after_reset");
    for (int n = 1; n <= 200; n++) begin
      step();
      check("tick_cadence", {31'd0, tick},
            {31'd0, (n >= 17) && (((n - 17) % 16) == 0)});
      check("idle_outputs", {16'd0, btn_level, btn_press, btn_release, press_cnt}, 32'd0);
    end

    // btn[0] press: accepted after the 3rd tick sampling 1.
    tick_step();
    btn = 3'b001;
    tick_step();
    tick_step();
    check("b0_press_early", {29'd0, btn_press}, 32'd0);
    check("b0_level_early", {29'd0, btn_level}, 32'd0);
    tick_step();
    check("b0_press", {29'd0, btn_press}, 32'b001);
    check("b0_level", {29'd0, btn_level}, 32'b001);
    step();
    check("b0_press_one_cycle", {29'd0, btn_press}, 32'd0);
    check("b0_press_cnt", {24'd0, press_cnt}, 32'd1);

    // btn[1] with a one-sample dip during ARMING restarts acceptance.
    tick_step();
    btn = 3'b011;
    tick_step();
    btn = 3'b001;
    tick_step();
    check("b1_dip_no_press", {29'd0, btn_press}, 32'd0);
    btn = 3'b011;
    tick_step();
    tick_step();
    check("b1_restart_no_press", {29'd0, btn_press}, 32'd0);
    tick_step();
    check("b1_press", {29'd0, btn_press}, 32'b010);
    step();
    check("b1_press_cnt", {24'd0, press_cnt}, 32'd2);

    // Short glitch on btn[2] between ticks is invisible.
    btn = 3'b111;
    repeat (3) step();
    btn = 3'b011;
    for (int k = 0; k < 4; k++) begin
      tick_step();
      check("glitch_level", {29'd0, btn_level}, 32'b011);
      check("glitch_press", {29'd0, btn_press}, 32'd0);
    end

    // Release btn[0], btn[1].
    btn = 3'b000;
    tick_step();
    tick_step();
    tick_step();
    check("b01_release", {29'd0, btn_release}, 32'b011);
    check("b01_level", {29'd0, btn_level}, 32'b000);

    // 84 rounds of triple press/release: 2 + 3*84 = 254.
    for (int r = 0; r < 84; r++) begin
      btn = 3'b111;
      tick_step();
      tick_step();
      tick_step();
      check("round_press", {29'd0, btn_press}, 32'b111);
      btn = 3'b000;
      tick_step();
      tick_step();
      tick_step();
      check("round_release", {29'd0, btn_release}, 32'b111);
    end
    step();
    check("cnt_254", {24'd0, press_cnt}, 32'd254);

    // Simultaneous press wraps 254 + 3 -> 1.
    btn = 3'b111;
    tick_step();
    tick_step();
    tick_step();
    check("all_press", {29'd0, btn_press}, 32'b111);
    step();
    check("cnt_wrap", {24'd0, press_cnt}, 32'd1);

    // Release btn[2] only.
    btn = 3'b011;
    tick_step();
    tick_step();
    check("b2_release_early", {29'd0, btn_release}, 32'd0);
    check("b2_level_disarming", {29'd0, btn_level}, 32'b111);
    tick_step();
    check("b2_release", {29'd0, btn_release}, 32'b100);
    check("b2_level", {29'd0, btn_level}, 32'b011);
    step();
    check("b2_release_one_cycle", {29'd0, btn_release}, 32'd0);
    check("b2_cnt_unchanged", {24'd0, press_cnt}, 32'd1);

    // Reset while btn[0] is ARMING with cnt=2.
    btn = 3'b000;
    tick_step();
    tick_step();
    tick_step();
    step();
    btn = 3'b001;
    tick_step();
    tick_step();
    rst = 1'b1;
    step();
    check_all_zero("mid_reset_outputs");
    step();
    rst = 1'b0;
    check_all_zero("post_reset_first_cycle");
    step();
    check_all_zero("post_reset_second_cycle");
    tick_step();
    tick_step();
    check("reaccept_early", {29'd0, btn_press}, 32'd0);
    tick_step();
    check("reaccept_press", {29'd0, btn_press}, 32'b001);
    check("reaccept_level", {29'd0, btn_level}, 32'b001);
    step();
    check("reaccept_cnt", {24'd0, press_cnt}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
